// File: rtl/accum_bus_arbiter.sv
// accum_bus_arbiter: round-robin share of one column accumulation bus among
// NUM_ROWS PEs. Each frame collects exactly one result per row in frame_mask.
// The beat that completes the frame is flagged with out_last.
// Optional feature: define ACCUM_ARB_TAG_EN to add the registered out_row tag.
module accum_bus_arbiter #(
    parameter int NUM_ROWS  = 4,
    parameter int ACCUM_BIT = 32,
    parameter int ROW_W     = $clog2(NUM_ROWS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ROWS*ACCUM_BIT-1:0] req_data,
    input  logic [NUM_ROWS-1:0]           req_valid,
    output logic [NUM_ROWS-1:0]           req_ready,
    input  logic [NUM_ROWS-1:0]           frame_mask,
    output logic [ACCUM_BIT-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
`ifdef ACCUM_ARB_TAG_EN
    output logic [ROW_W-1:0]              out_row,
`endif
    output logic                          busy
);

    logic [ROW_W-1:0]     last_grant_q;
    logic [NUM_ROWS-1:0]  served_q;
    logic [ACCUM_BIT-1:0] data_q;
    logic                 valid_q;
    logic                 last_q;

    logic [NUM_ROWS-1:0]  eligible;
    logic [NUM_ROWS-1:0]  grant_oh;
    logic [ROW_W-1:0]     grant_idx;
    logic                 load_en;
    logic                 accept;
    logic                 frame_done;

    assign eligible = req_valid & frame_mask & ~served_q;
    assign load_en  = ~valid_q | out_ready;

    // Rotating priority scan starting just after the most recent grant
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_ROWS; k++) begin
            int idx;
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_ROWS) idx = idx - NUM_ROWS;
            if (grant_oh == '0 && eligible[idx]) begin
                grant_oh[idx] = 1'b1;
                grant_idx     = ROW_W'(idx);
            end
        end
    end

    // Ready is suppressed during reset and whenever the output stage is held
    assign req_ready  = rst ? '0 : (grant_oh & {NUM_ROWS{load_en}});
    assign accept     = |req_ready;
    assign frame_done = ((served_q | grant_oh) & frame_mask) == frame_mask;

    // Arbitration state and single output register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ROW_W'(NUM_ROWS - 1);
            served_q     <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else if (accept) begin
            data_q       <= req_data[int'(grant_idx)*ACCUM_BIT +: ACCUM_BIT];
            valid_q      <= 1'b1;
            last_q       <= frame_done;
            last_grant_q <= grant_idx;
            served_q     <= frame_done ? '0 : (served_q | grant_oh);
        end else if (out_ready && valid_q) begin
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end
    end

`ifdef ACCUM_ARB_TAG_EN
    logic [ROW_W-1:0] row_q;

    // Source row tag travels with the data beat
    always_ff @(posedge clk) begin
        if (rst)         row_q <= '0;
        else if (accept) row_q <= grant_idx;
    end

    assign out_row = row_q;
`endif

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (served_q != '0) | valid_q;

endmodule

// File: tb/tb_accum_bus_arbiter.sv
// Directed bench for accum_bus_arbiter (NUM_ROWS=4, ACCUM_BIT=32).
module tb_accum_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] req_data;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   frame_mask;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [1:0]   out_row;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    accum_bus_arbiter #(.NUM_ROWS(4), .ACCUM_BIT(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .frame_mask (frame_mask),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
`ifdef ACCUM_ARB_TAG_EN
        .out_row    (out_row),
`endif
        .busy       (busy)
    );

`ifndef ACCUM_ARB_TAG_EN
    assign out_row = 2'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b0; frame_mask = 4'b0; out_ready = 1'b1;
        req_data = {32'd49, 32'd33, 32'd17, 32'd1};
        tick(); tick();
        checks++;
        if ({out_valid, out_last, out_data, busy} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b l=%0b d=%0d busy=%0b exp all 0", out_valid, out_last, out_data, busy);
        end
        req_valid = 4'b1111; frame_mask = 4'b1111; #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got %b exp 0000", req_ready);
        end
        rst = 1'b0; req_valid = 4'b0; #1;
    endtask

    task automatic test_priority();
        logic [31:0] exp_d [4] = '{32'd1, 32'd17, 32'd33, 32'd49};
        req_valid = 4'b1111; frame_mask = 4'b1111; out_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL prio_first_ready got %b exp 0001", req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, (k == 3), exp_d[k]}) begin
                failures++;
                $display("FAIL prio_beat%0d got v=%0b l=%0b d=%0d exp v=1 l=%0b d=%0d", k, out_valid, out_last, out_data, (k == 3), exp_d[k]);
            end
`ifdef ACCUM_ARB_TAG_EN
            checks++;
            if (out_row !== 2'(k)) begin
                failures++;
                $display("FAIL prio_row%0d got %0d exp %0d", k, out_row, k);
            end
`endif
        end
        req_valid = 4'b0;
        tick();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL prio_drain got v=%0b busy=%0b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1111; frame_mask = 4'b1111; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick(); else #1;
            checks++;
            if ({out_valid, out_data, req_ready} !== {1'b1, 32'd1, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%0b d=%0d rdy=%b exp v=1 d=1 rdy=0000", k, out_valid, out_data, req_ready);
            end
        end
        tick();
        checks++;
        if ({out_valid, out_data, req_ready} !== {1'b1, 32'd1, 4'b0000}) begin
            failures++;
            $display("FAIL bp_hold3 got v=%0b d=%0d rdy=%b exp v=1 d=1 rdy=0000", out_valid, out_data, req_ready);
        end
        out_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release_ready got %b exp 0010", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'd17}) begin
            failures++;
            $display("FAIL bp_next got v=%0b l=%0b d=%0d exp v=1 l=0 d=17", out_valid, out_last, out_data);
        end
        tick(); tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'd49}) begin
            failures++;
            $display("FAIL bp_last got v=%0b l=%0b d=%0d exp v=1 l=1 d=49", out_valid, out_last, out_data);
        end
        req_valid = 4'b0;
        tick();
    endtask

    task automatic test_mask();
        frame_mask = 4'b0000; req_valid = 4'b1111; #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mask_zero_ready got %b exp 0000", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL mask_zero_out got v=%0b busy=%0b exp 0 0", out_valid, busy);
        end
        frame_mask = 4'b0101; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mask_ready0 got %b exp 0001", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data, req_ready} !== {1'b1, 1'b0, 32'd1, 4'b0100}) begin
            failures++;
            $display("FAIL mask_row0 got v=%0b l=%0b d=%0d rdy=%b exp v=1 l=0 d=1 rdy=0100", out_valid, out_last, out_data, req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data, req_ready} !== {1'b1, 1'b1, 32'd33, 4'b0001}) begin
            failures++;
            $display("FAIL mask_row2 got v=%0b l=%0b d=%0d rdy=%b exp v=1 l=1 d=33 rdy=0001", out_valid, out_last, out_data, req_ready);
        end
        req_valid = 4'b0;
        tick();
    endtask

    task automatic test_one_per_frame();
        frame_mask = 4'b0011; req_valid = 4'b0010; #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL opf_ready1 got %b exp 0010", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data, req_ready} !== {1'b1, 1'b0, 32'd17, 4'b0000}) begin
            failures++;
            $display("FAIL opf_first got v=%0b l=%0b d=%0d rdy=%b exp v=1 l=0 d=17 rdy=0000", out_valid, out_last, out_data, req_ready);
        end
        tick(); tick();
        checks++;
        if ({out_valid, busy, req_ready} !== {1'b0, 1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL opf_stall got v=%0b busy=%0b rdy=%b exp v=0 busy=1 rdy=0000", out_valid, busy, req_ready);
        end
        req_valid = 4'b0011; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL opf_ready0 got %b exp 0001", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data, req_ready} !== {1'b1, 1'b1, 32'd1, 4'b0010}) begin
            failures++;
            $display("FAIL opf_close got v=%0b l=%0b d=%0d rdy=%b exp v=1 l=1 d=1 rdy=0010", out_valid, out_last, out_data, req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'd17}) begin
            failures++;
            $display("FAIL opf_newframe got v=%0b l=%0b d=%0d exp v=1 l=0 d=17", out_valid, out_last, out_data);
        end
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0;
        tick();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL opf_idle got v=%0b busy=%0b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_rr_wrap();
        frame_mask = 4'b1000; req_valid = 4'b1000;
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'd49}) begin
            failures++;
            $display("FAIL single_beat0 got v=%0b l=%0b d=%0d exp v=1 l=1 d=49", out_valid, out_last, out_data);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'd49}) begin
            failures++;
            $display("FAIL single_beat1 got v=%0b l=%0b d=%0d exp v=1 l=1 d=49", out_valid, out_last, out_data);
        end
        req_valid = 4'b0;
        tick();
        frame_mask = 4'b1001; req_valid = 4'b1001; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_ready got %b exp 0001", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL wrap_row0 got v=%0b l=%0b d=%0d exp v=1 l=0 d=1", out_valid, out_last, out_data);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'd49}) begin
            failures++;
            $display("FAIL wrap_row3 got v=%0b l=%0b d=%0d exp v=1 l=1 d=49", out_valid, out_last, out_data);
        end
        req_valid = 4'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        frame_mask = 4'b1111; req_valid = 4'b1111;
        tick(); tick();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'd17}) begin
            failures++;
            $display("FAIL mrst_pre got v=%0b d=%0d exp v=1 d=17", out_valid, out_data);
        end
        rst = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mrst_ready got %b exp 0000", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL mrst_out got v=%0b busy=%0b exp 0 0", out_valid, busy);
        end
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mrst_prio got %b exp 0001", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL mrst_beat got v=%0b l=%0b d=%0d exp v=1 l=0 d=1", out_valid, out_last, out_data);
        end
`ifdef ACCUM_ARB_TAG_EN
        checks++;
        if (out_row !== 2'd0) begin
            failures++;
            $display("FAIL mrst_row got %0d exp 0", out_row);
        end
`endif
        req_valid = 4'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_backpressure();
        test_mask();
        test_one_per_frame();
        test_rr_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
